// File: rtl/gan_pkg.sv
// gan_pkg: shared FSM encoding and activation constants for the GAN MAC engine
package gan_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_OUT} state_t;
  localparam logic [1:0] ACT_NONE  = 2'd0;
  localparam logic [1:0] ACT_RELU  = 2'd1;
  localparam logic [1:0] ACT_LEAKY = 2'd2;
  localparam int LEAKY_SH = 3;
endpackage

// File: rtl/q_round_sat_act.sv
// q_round_sat_act: round-half-up, saturate to DATA_W and apply activation
module q_round_sat_act
  import gan_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic        [1:0]        act,
  output logic        [DATA_W-1:0] res,
  output logic                     sat
);
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  logic signed [ACC_W-1:0]  sum, rnd;
  logic signed [DATA_W-1:0] sv, leak;
  logic hi, lo;
  assign sum  = acc + HALF;
  assign rnd  = sum >>> FRAC_W;
  assign hi   = rnd > MAXV;
  assign lo   = rnd < MINV;
  assign sat  = hi | lo;
  assign sv   = hi ? {1'b0, {(DATA_W-1){1'b1}}} : lo ? {1'b1, {(DATA_W-1){1'b0}}} : rnd[DATA_W-1:0];
  // computed apart so the arithmetic shift keeps its signedness
  assign leak = sv >>> LEAKY_SH;
  assign res  = !sv[DATA_W-1] ? sv : act == ACT_RELU ? '0 : act == ACT_LEAKY ? leak : sv;
endmodule

// File: rtl/gan_mac_engine.sv
// gan_mac_engine: fixed-point dot product with bias, rounding, saturation and activation
module gan_mac_engine
  import gan_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int ACC_W   = 40,
  parameter int VEC_LEN = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic        [1:0]        act_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] in_weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic                     busy
);
  localparam int CW = $clog2(VEC_LEN + 1);
  state_t state, state_n;
  logic signed [ACC_W-1:0]    acc;
  logic        [CW-1:0]       cnt;
  logic        [1:0]          act_q;
  logic signed [2*DATA_W-1:0] prod;
  logic        [DATA_W-1:0]   res;
  logic                       sat, beat, last;
  assign prod = in_data * in_weight;
  assign beat = in_valid && in_ready;
  assign last = cnt == CW'(VEC_LEN - 1);
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_ACCUM : S_IDLE;
      S_ACCUM: state_n = beat && last ? S_FINAL : S_ACCUM;
      S_FINAL: state_n = S_OUT;
      S_OUT:   state_n = out_ready ? S_IDLE : S_OUT;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == S_ACCUM;
    out_valid = state == S_OUT;
    busy      = state != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      act_q    <= ACT_NONE;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        acc   <= {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC_W;
        act_q <= act_mode;
        cnt   <= '0;
      end
      if (beat) begin
        acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        cnt <= cnt + CW'(1);
      end
      if (state == S_FINAL) begin
        out_data <= res;
        out_sat  <= sat;
      end
    end
  end
  q_round_sat_act #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_rsa (
    .acc(acc),
    .act(act_q),
    .res(res),
    .sat(sat)
  );
endmodule

// File: tb/tb_gan_mac_engine.sv
// tb_gan_mac_engine: directed vectors with hand-computed results for gan_mac_engine
module tb_gan_mac_engine;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready, out_sat, busy;
  logic [15:0] bias, in_data, in_weight, out_data;
  logic [1:0]  act_mode;
  logic [15:0] d_v [8];
  logic [15:0] w_v [8];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gan_mac_engine dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .act_mode(act_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [15:0] d0, w0, dr, wr);
    for (int i = 0; i < 8; i++) begin
      d_v[i] = i == 0 ? d0 : dr;
      w_v[i] = i == 0 ? w0 : wr;
    end
  endtask

  task automatic run(input string tag, input logic [15:0] b, input logic [1:0] a,
                     input bit gaps, input int stall, input logic [15:0] exp_d, input logic exp_s);
    int n = 0;
    int cyc = 0;
    bias = b; act_mode = a; start = 1'b1;
    tick();
    start = 1'b0;
    bias = 16'h1234; act_mode = 2'd1;
    chk({tag, "_busy"}, busy, 1);
    while (n < 8 && cyc < 200) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data = d_v[n]; in_weight = w_v[n];
      start = gaps;
      tick();
      if (in_valid) n++;
      cyc++;
    end
    if (n < 8) chk({tag, "_beat_timeout"}, n, 8);
    in_valid = 1'b0; start = 1'b0;
    chk({tag, "_lat_early"}, out_valid, 0);
    tick();
    chk({tag, "_lat"}, out_valid, 1);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0; start = 1'b1;
      chk({tag, "_stall_data"}, out_data, exp_d);
      tick();
    end
    out_ready = 1'b1; start = 1'b1;
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_sat"}, out_sat, exp_s);
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, busy, 0);
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; act_mode = '0;
    in_valid = 1'b0; in_data = '0; in_weight = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    tick();

    set_vec(16'h0100, 16'h0080, 16'h0100, 16'h0080);
    run("basic", 16'h0040, 2'd0, 1'b0, 0, 16'h0440, 1'b0);
    set_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    run("sat_pos", 16'h7FFF, 2'd0, 1'b0, 0, 16'h7FFF, 1'b1);
    set_vec(16'h7FFF, 16'h8001, 16'h7FFF, 16'h8001);
    run("sat_neg", 16'h7FFF, 2'd0, 1'b0, 0, 16'h8000, 1'b1);
    set_vec(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run("act_none", 16'hFF00, 2'd0, 1'b0, 0, 16'hFF00, 1'b0);
    run("act_relu", 16'hFF00, 2'd1, 1'b0, 0, 16'h0000, 1'b0);
    run("act_leaky", 16'hFF00, 2'd2, 1'b0, 0, 16'hFFE0, 1'b0);
    run("act_three", 16'hFF00, 2'd3, 1'b0, 0, 16'hFF00, 1'b0);
    set_vec(16'h0001, 16'h0080, 16'h0000, 16'h0000);
    run("round_up", 16'h0000, 2'd0, 1'b0, 0, 16'h0001, 1'b0);
    set_vec(16'hFFFF, 16'h0080, 16'h0000, 16'h0000);
    run("round_neg", 16'h0000, 2'd0, 1'b0, 0, 16'h0000, 1'b0);
    set_vec(16'h0100, 16'h0080, 16'h0100, 16'h0080);
    run("stall", 16'h0040, 2'd0, 1'b1, 5, 16'h0440, 1'b0);

    bias = 16'h7FFF; act_mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h7FFF; in_weight = 16'h7FFF;
      tick();
    end
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    tick();
    run("after_rst", 16'h0040, 2'd0, 1'b0, 0, 16'h0440, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gan_mac_engine.md
GAN_MAC_ENGINE -- requirements
Module: gan_mac_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed fixed-point operand/result width.
REQ-002 SHALL have parameter FRAC_W, default 8, fractional bits (Q8.8 at defaults).
REQ-003 SHALL have parameter ACC_W, default 40, accumulator width; legal only when ACC_W >= 2*DATA_W + clog2(VEC_LEN) + 1.
REQ-004 SHALL have parameter VEC_LEN, default 8, number of input/weight pairs per dot product (>= 1).
REQ-005 SHALL have the following ports, and SHALL use one clock with synchronous, active-high reset:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a dot product; sampled only in IDLE
- bias  input  DATA_W  signed bias, captured with start
- act_mode  input  2  activation, captured with start
- in_valid  input  1  operand beat valid
- in_ready  output  1  engine accepts an operand beat
- in_data  input  DATA_W  signed activation operand
- in_weight  input  DATA_W  signed weight operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  DATA_W  signed result
- out_sat  output  1  result was clipped during saturation
- busy  output  1  high in every state except IDLE

Function
REQ-006 The FSM SHALL have states IDLE, ACCUM, FINAL and OUT.
REQ-007 IDLE: start=1 SHALL load acc = sign-extended bias << FRAC_W, capture act_mode, clear the beat counter and go to ACCUM.
REQ-008 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid && in_ready.
REQ-009 On each accepted beat, acc SHALL become acc + sign-extended (in_data*in_weight) with a full 2*DATA_W signed product, and the counter SHALL increment.
REQ-010 On the VEC_LEN-th accepted beat, the FSM SHALL go to FINAL; with no beat accepted, it SHALL hold in ACCUM without limit.
REQ-011 FINAL SHALL last one cycle; it SHALL compute r = (acc + 2^(FRAC_W-1)) >>> FRAC_W (round half up, arithmetic shift).
REQ-012 In FINAL, r SHALL be clipped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; clipping SHALL set out_sat=1, otherwise out_sat=0.
REQ-013 In FINAL, activation SHALL apply after saturation:
- act_mode 0: none
- act_mode 1: ReLU (negative -> 0)
- act_mode 2: leaky (negative -> x >>> 3, i.e. slope 0.125)
- act_mode 3: same as act_mode 0
REQ-014 FINAL SHALL register out_data and out_sat, then go to OUT.
REQ-015 OUT: out_valid=1, and out_data/out_sat SHALL stay stable until out_ready=1; on that handshake the FSM SHALL go to IDLE.
REQ-016 Latency: when the last beat is accepted in cycle T, out_valid SHALL first be high in cycle T+2.
REQ-017 start SHALL be ignored outside IDLE, including in the cycle of the output handshake; the next start SHALL be accepted in IDLE at the earliest one cycle after the handshake.
REQ-018 Changes to bias or act_mode after start SHALL NOT affect the current operation.
REQ-019 Accumulation SHALL never overflow given the REQ-003 constraint; no intermediate saturation.

Reset
REQ-020 On rst=1 at a clock edge, the following SHALL apply in any state, including mid-ACCUM or OUT:
- state = IDLE
- acc and counter cleared
- in_ready = 0, out_valid = 0, busy = 0
- out_data = 0, out_sat = 0
REQ-021 Any partial result SHALL be discarded; rst SHALL take priority over start and all handshakes in the same cycle.

Structure
REQ-022 Shared package gan_pkg SHALL hold:
- FSM state encoding
- act_mode constants ACT_NONE, ACT_RELU, ACT_LEAKY
- leaky shift constant (3)
REQ-023 Rounding, saturation and activation SHALL be one combinational sub-module, q_round_sat_act (parameters DATA_W, FRAC_W, ACC_W).
REQ-024 The FSM, counter, accumulator and handshake logic SHALL stay in gan_mac_engine.

Verification (defaults unless stated)
REQ-025 bias 0x0040 (0.25), act 0, 8 beats in_data 0x0100, in_weight 0x0080 -> out_data 0x0440 (4.25), out_sat 0, out_valid two cycles after the last beat.
REQ-026 8 beats of 0x7FFF x 0x7FFF, bias 0x7FFF -> out_data 0x7FFF, out_sat 1; same with in_weight 0x8001 -> out_data 0x8000, out_sat 1.
REQ-027 bias 0xFF00 (-1.0), zero operands -> act 0: 0xFF00; act 1: 0x0000; act 2: 0xFFE0 (-0.125).
REQ-028 Rounding, bias 0, one beat 0x0001 x 0x0080, rest zero -> out_data 0x0001; one beat 0xFFFF x 0x0080 -> out_data 0x0000.
REQ-029 Random in_valid gaps and out_ready held low 5 cycles -> the REQ-025 result is unchanged and out_data is stable while stalled; start pulses while busy are ignored.
REQ-030 rst asserted after 4 accepted beats -> busy, in_ready and out_valid are 0 next cycle; a fresh REQ-025 run then yields 0x0440.
